mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-port 8-bit RAM between two requesters:
  - m0: CPU control sequencer.
  - m1: program loader.
- Sequences every access onto the RAM's addr/ie/oe controls and onto the shared tri-state system bus.
- Round-robin arbitration, with an optional bounded lock for back-to-back bursts.
- One access per grant; fixed 3-cycle request-to-ack latency when uncontended.

Parameters:
ADDR_W, 8, address width of RAM and requester addr ports
DATA_W, 8, data width of bus, wdata and rdata
MAX_LOCK, 4, max consecutive grants one locked master may hold before forced rotation (>=1)

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
m0_req  input  1  m0 access request; held with addr/we/wdata stable until m0_ack
m0_we  input  1  1=write, 0=read
m0_lock  input  1  request to keep grant for next access
m0_addr  input  ADDR_W  access address
m0_wdata  input  DATA_W  write data
m0_ack  output  1  one-cycle completion pulse
m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_ack  same as m0 for master 1
rdata  output  DATA_W  read data; valid in the cycle the ack for a read is high, held until next read
mem_addr  output  ADDR_W  RAM address
mem_ie  output  1  RAM write enable (RAM writes on negedge while high)
mem_oe  output  1  RAM output enable onto bus
bus  inout  DATA_W  shared system bus; driven with wdata only while mem_ie=1, else Z
busy  output  1  high whenever state != IDLE
owner  output  1  index of the currently/last granted master

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- FSM states: IDLE, ACCESS, RESP.
- Reset values:
  - state=IDLE.
  - mem_ie=0, mem_oe=0, mem_addr=0.
  - bus=Z, m0_ack=0, m1_ack=0, rdata=0, busy=0.
  - owner=1, so m0 wins the first contention.
  - lock_cnt=0.
- IDLE: on a posedge with at least one req, pick a winner and go to ACCESS. Latch the winner's addr/we/wdata into internal registers.
  - Only one requester: grant it.
  - Both requesting, lock in effect (owner's lock was high at its last RESP and lock_cnt<MAX_LOCK): grant owner.
  - Both requesting, otherwise: grant !owner.
  - Set owner=winner.
- ACCESS (exactly 1 cycle):
  - mem_addr=latched addr.
  - Write: mem_ie=1 and bus=latched wdata.
  - Read: mem_oe=1, bus=Z from this block.
  - At the posedge ending ACCESS: a read captures bus into rdata. Then go to RESP.
- RESP (1 cycle):
  - mem_ie=0, mem_oe=0, bus=Z.
  - Winner's ack=1; the other ack=0.
  - lock_cnt update:
    - Winner's lock=1: lock_cnt+1, saturating at MAX_LOCK.
    - Winner's lock=0: lock_cnt cleared.
  - Next state IDLE.
- Latency: req seen high at edge E → ACCESS after E → ack high in the cycle after E+1. Three cycles from req to ack inclusive; a minimum of 3 cycles per access.
- Lock expiry: when lock_cnt==MAX_LOCK and the other master is requesting, grant the other master and clear lock_cnt. If the other master is not requesting, the owner keeps being served and lock_cnt stays saturated.
- Requests are level-sensitive: a master keeping req high after ack is treated as a new request in IDLE. The 1-cycle IDLE gap is mandatory.
- Changes to addr/we/wdata after the IDLE latch are ignored for that access.
- Deasserting req before ack is a protocol violation; the latched access still completes and ack still pulses.
- mem_ie and mem_oe are never both 1. bus is never driven except in a write ACCESS.
- Reset asserted in any state: next edge forces all reset values. Any in-flight access is dropped with no ack. A write ACCESS cut by reset may already have committed at that cycle's negedge; that is accepted.

Test Plan:
- Reset then write: m0 writes 0xA5 to 0x10.
  - Expect mem_ie=1, mem_addr=0x10, bus=0xA5 for exactly 1 cycle.
  - m0_ack pulses 2 cycles after the IDLE latch edge.
  - A subsequent m0 read of 0x10 returns rdata=0xA5 with ack.
- Simultaneous m0/m1 reads after reset, no lock: m0 is granted first, then m1. m1_ack comes 3 cycles after m0_ack. Both rdata values match RAM contents.
- Both masters holding req continuously, no lock: grants strictly alternate m0, m1, m0, m1. Each ack is spaced 3 cycles apart.
- MAX_LOCK=4, m1 requesting with lock=1, m0 requesting throughout: m1 gets 4 consecutive grants (counted from the first locked access), then m0 is granted and lock_cnt reads 0.
- Reset during a read ACCESS: next cycle state=IDLE, mem_oe=0, no ack, bus=Z, rdata=0. A following request completes normally.
- Check every cycle of all the above: mem_ie&mem_oe is never 1, and bus is Z whenever mem_ie=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for a single-port RAM and its shared tri-state bus.
// Each grant runs IDLE -> ACCESS -> RESP; a locking master may hold up to MAX_LOCK grants in a row.
module mem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ie,
    output logic              mem_oe,
    inout  wire  [DATA_W-1:0] bus,
    output logic              busy,
    output logic              owner
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]        req_vec;
    logic [1:0]        we_vec;
    logic [1:0]        lock_vec;
    logic [1:0]        ack_vec;
    logic [ADDR_W-1:0] addr_arr  [2];
    logic [DATA_W-1:0] wdata_arr [2];

    logic [1:0]        state_reg,     state_next;
    logic              owner_reg,     owner_next;
    logic              we_reg,        we_next;
    logic [ADDR_W-1:0] addr_reg,      addr_next;
    logic [DATA_W-1:0] wdata_reg,     wdata_next;
    logic [DATA_W-1:0] rdata_reg,     rdata_next;
    logic              lock_flag_reg, lock_flag_next;
    logic [CNT_W-1:0]  lock_cnt_reg,  lock_cnt_next;
    logic              win;

    assign req_vec      = {m1_req, m0_req};
    assign we_vec       = {m1_we, m0_we};
    assign lock_vec     = {m1_lock, m0_lock};
    assign addr_arr[0]  = m0_addr;
    assign addr_arr[1]  = m1_addr;
    assign wdata_arr[0] = m0_wdata;
    assign wdata_arr[1] = m1_wdata;

    // The ack for master gi is the RESP cycle of an access it owns.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ack
            assign ack_vec[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign m0_ack   = ack_vec[0];
    assign m1_ack   = ack_vec[1];
    assign rdata    = rdata_reg;
    assign mem_addr = addr_reg;
    assign mem_ie   = (state_reg == ACCESS) && we_reg;
    assign mem_oe   = (state_reg == ACCESS) && !we_reg;
    assign bus      = mem_ie ? wdata_reg : {DATA_W{1'bz}};
    assign busy     = (state_reg != IDLE);
    assign owner    = owner_reg;

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        we_next        = we_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        rdata_next     = rdata_reg;
        lock_flag_next = lock_flag_reg;
        lock_cnt_next  = lock_cnt_reg;
        win            = owner_reg;
        case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    if (req_vec == 2'b11) begin
                        // A live lock keeps the owner; otherwise rotate away from it.
                        if (lock_flag_reg && (lock_cnt_reg < LOCK_MAX))
                            win = owner_reg;
                        else
                            win = !owner_reg;
                    end else begin
                        win = req_vec[1];
                    end
                    if (win != owner_reg)
                        lock_cnt_next = '0;
                    owner_next = win;
                    we_next    = we_vec[win];
                    addr_next  = addr_arr[win];
                    wdata_next = wdata_arr[win];
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_reg)
                    rdata_next = bus;
                state_next = RESP;
            end
            RESP: begin
                lock_flag_next = lock_vec[owner_reg];
                if (lock_vec[owner_reg])
                    lock_cnt_next = (lock_cnt_reg == LOCK_MAX) ? lock_cnt_reg : lock_cnt_reg + 1'b1;
                else
                    lock_cnt_next = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b1;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            lock_flag_reg <= 1'b0;
            lock_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            rdata_reg     <= rdata_next;
            lock_flag_reg <= lock_flag_next;
            lock_cnt_reg  <= lock_cnt_next;
        end
    end

endmodule
